// File: rtl/fill_arbiter.sv
// Two-requester range-fill engine that owns a DEPTH x DW register array.
// Commands are arbitrated round-robin and written back one word per cycle.
module fill_arbiter #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_a_valid,
  output logic          o_a_ready,
  input  logic [AW-1:0] i_a_start,
  input  logic [AW-1:0] i_a_end,
  input  logic [DW-1:0] i_a_data,
  output logic          o_a_done,
  input  logic          i_b_valid,
  output logic          o_b_ready,
  input  logic [AW-1:0] i_b_start,
  input  logic [AW-1:0] i_b_end,
  input  logic [DW-1:0] i_b_data,
  output logic          o_b_done,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data,
  output logic          o_busy
);

  typedef enum logic [0:0] {StIdle, StFill} state_e;
  typedef enum logic [0:0] {GrantA, GrantB} grant_e;

  state_e        r_state,      w_state_d;
  grant_e        r_last_grant, w_last_grant_d;
  grant_e        r_owner,      w_owner_d;
  logic [AW-1:0] r_cur_ptr,    w_cur_ptr_d;
  logic [AW-1:0] r_cur_end,    w_cur_end_d;
  logic [DW-1:0] r_cur_data,   w_cur_data_d;
  logic          r_a_done,     w_a_done_d;
  logic          r_b_done,     w_b_done_d;
  logic          w_a_grant,    w_b_grant;
  logic          w_we;
  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rd_data;

  // On a tie the requester that was not granted last wins.
  always_comb begin
    w_a_grant = 1'b0;
    w_b_grant = 1'b0;
    if (r_state == StIdle) begin
      w_a_grant = i_a_valid & (~i_b_valid | (r_last_grant == GrantB));
      w_b_grant = i_b_valid & (~i_a_valid | (r_last_grant == GrantA));
    end
  end

  always_comb begin
    w_state_d      = r_state;
    w_last_grant_d = r_last_grant;
    w_owner_d      = r_owner;
    w_cur_ptr_d    = r_cur_ptr;
    w_cur_end_d    = r_cur_end;
    w_cur_data_d   = r_cur_data;
    w_a_done_d     = 1'b0;
    w_b_done_d     = 1'b0;
    w_we           = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_a_grant) begin
          w_state_d      = StFill;
          w_owner_d      = GrantA;
          w_last_grant_d = GrantA;
          w_cur_ptr_d    = i_a_start;
          w_cur_end_d    = i_a_end;
          w_cur_data_d   = i_a_data;
        end else if (w_b_grant) begin
          w_state_d      = StFill;
          w_owner_d      = GrantB;
          w_last_grant_d = GrantB;
          w_cur_ptr_d    = i_b_start;
          w_cur_end_d    = i_b_end;
          w_cur_data_d   = i_b_data;
        end
      end
      StFill: begin
        w_we = 1'b1;
        if (r_cur_ptr == r_cur_end) begin
          w_state_d  = StIdle;
          w_a_done_d = (r_owner == GrantA);
          w_b_done_d = (r_owner == GrantB);
        end else begin
          // DEPTH is a power of two, so AW-bit overflow is the modulo wrap.
          w_cur_ptr_d = r_cur_ptr + AW'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_last_grant <= GrantB;
      r_owner      <= GrantA;
      r_cur_ptr    <= '0;
      r_cur_end    <= '0;
      r_cur_data   <= '0;
      r_a_done     <= 1'b0;
      r_b_done     <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_last_grant <= w_last_grant_d;
      r_owner      <= w_owner_d;
      r_cur_ptr    <= w_cur_ptr_d;
      r_cur_end    <= w_cur_end_d;
      r_cur_data   <= w_cur_data_d;
      r_a_done     <= w_a_done_d;
      r_b_done     <= w_b_done_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (w_we) begin
      r_mem[r_cur_ptr] <= r_cur_data;
    end
  end

  // Sampled before the same-edge write lands, so a colliding read sees the old word.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_rd_data <= '0;
    else          r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_a_ready = w_a_grant;
  assign o_b_ready = w_b_grant;
  assign o_a_done  = r_a_done;
  assign o_b_done  = r_b_done;
  assign o_rd_data = r_rd_data;
  assign o_busy    = (r_state == StFill);

endmodule

// File: tb/tb_fill_arbiter.sv
// Randomized and directed bench for fill_arbiter against a countdown-based
// transaction model of the array and arbitration.
module tb_fill_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, b_valid;
  logic       a_ready, b_ready, a_done, b_done, busy;
  logic [3:0] a_start, a_end, b_start, b_end, rd_addr;
  logic [7:0] a_data, b_data, rd_data;

  int n_tests = 0;
  int n_fail  = 0;

  fill_arbiter #(.DW(8), .DEPTH(16), .AW(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_valid(a_valid), .o_a_ready(a_ready), .i_a_start(a_start), .i_a_end(a_end),
    .i_a_data(a_data), .o_a_done(a_done),
    .i_b_valid(b_valid), .o_b_ready(b_ready), .i_b_start(b_start), .i_b_end(b_end),
    .i_b_data(b_data), .o_b_done(b_done),
    .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: a fill is "rem words left to write starting at ptr".
  logic [7:0] m_mem [16];
  int         m_rem, m_ptr, m_owner, m_last;
  logic [7:0] m_data;
  bit         m_acc_a, m_acc_b, chk_en;
  logic       e_busy, e_adone, e_bdone;
  logic [7:0] e_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called just after a falling edge with inputs already driven; advances one cycle.
  task automatic step();
    bit idle, ea, eb;
    #1;
    idle = (m_rem == 0);
    ea   = idle && a_valid && (!b_valid || m_last == 1);
    eb   = idle && b_valid && (!a_valid || m_last == 0);
    if (chk_en) begin
      check("busy", busy, e_busy);
      check("a_done", a_done, e_adone);
      check("b_done", b_done, e_bdone);
      check("rd_data", rd_data, e_rd);
      check("a_ready", a_ready, ea);
      check("b_ready", b_ready, eb);
    end
    m_acc_a = 0;
    m_acc_b = 0;
    if (!rst_n) begin
      m_rem   = 0;
      m_last  = 1;
      e_adone = 0;
      e_bdone = 0;
      e_rd    = 8'h00;
      for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    end else begin
      e_rd    = m_mem[rd_addr];
      e_adone = 0;
      e_bdone = 0;
      if (m_rem > 0) begin
        m_mem[m_ptr] = m_data;
        m_ptr = (m_ptr + 1) % 16;
        m_rem--;
        if (m_rem == 0) begin
          if (m_owner == 0) e_adone = 1;
          else              e_bdone = 1;
        end
      end else if (ea || eb) begin
        m_owner = ea ? 0 : 1;
        m_last  = m_owner;
        m_ptr   = ea ? int'(a_start) : int'(b_start);
        m_data  = ea ? a_data : b_data;
        m_rem   = ea ? ((int'(a_end) - int'(a_start) + 16) % 16) + 1
                     : ((int'(b_end) - int'(b_start) + 16) % 16) + 1;
        m_acc_a = ea;
        m_acc_b = eb && !ea;
      end
    end
    e_busy = (m_rem > 0);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    a_valid = 0;
    b_valid = 0;
    rst_n   = 0;
    repeat (n) step();
    rst_n = 1;
  endtask

  task automatic run_cmds(input bit use_a, input logic [3:0] as, input logic [3:0] ae,
                          input logic [7:0] ad, input bit use_b, input logic [3:0] bs,
                          input logic [3:0] be, input logic [7:0] bd);
    bit need_a = use_a, need_b = use_b;
    int k = 0;
    a_start = as; a_end = ae; a_data = ad; a_valid = use_a;
    b_start = bs; b_end = be; b_data = bd; b_valid = use_b;
    while ((need_a || need_b) && k < 60) begin
      step();
      if (m_acc_a) begin need_a = 0; a_valid = 0; end
      if (m_acc_b) begin need_b = 0; b_valid = 0; end
      k++;
    end
    if (need_a || need_b) check("accept_timeout", 0, 1);
    a_valid = 0;
    b_valid = 0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (m_rem > 0 && k < 40) begin step(); k++; end
    if (m_rem > 0) check("idle_timeout", 0, 1);
    step();
  endtask

  task automatic read_chk(input string tag, input logic [3:0] addr, input logic [7:0] exp);
    rd_addr = addr;
    step();
    check(tag, rd_data, exp);
  endtask

  initial begin
    rst_n = 0; a_valid = 0; b_valid = 0; rd_addr = 0;
    a_start = 0; a_end = 0; a_data = 0; b_start = 0; b_end = 0; b_data = 0;
    m_rem = 0; m_last = 1; m_ptr = 0; m_owner = 0; m_data = 0; chk_en = 0;
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    @(negedge clk);
    step();
    chk_en = 1;
    do_reset(1);

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_a_done", a_done, 0);
    check("rst_b_done", b_done, 0);
    for (int i = 0; i < 16; i++) read_chk("rst_sweep", 4'(i), 8'h00);

    // Single fill 1..6
    run_cmds(1, 4'd1, 4'd6, 8'h5A, 0, 4'd0, 4'd0, 8'h00);
    check("single_busy_first", busy, 1);
    wait_idle();
    for (int i = 0; i < 16; i++)
      read_chk("single_sweep", 4'(i), (i >= 1 && i <= 6) ? 8'h5A : 8'h00);

    // Simultaneous requests after reset: A wins the first tie
    do_reset(2);
    a_valid = 1; b_valid = 1;
    #1;
    check("tie_a_ready", a_ready, 1);
    check("tie_b_ready", b_ready, 0);
    run_cmds(1, 4'd0, 4'd3, 8'h11, 1, 4'd2, 4'd5, 8'h22);
    wait_idle();
    for (int i = 0; i < 16; i++)
      read_chk("tie_sweep", 4'(i), (i <= 1) ? 8'h11 : (i <= 5) ? 8'h22 : 8'h00);

    // Wrap-around fill 14..1
    do_reset(2);
    run_cmds(0, 4'd0, 4'd0, 8'h00, 1, 4'd14, 4'd1, 8'hC3);
    wait_idle();
    for (int i = 0; i < 16; i++)
      read_chk("wrap_sweep", 4'(i), (i >= 14 || i <= 1) ? 8'hC3 : 8'h00);

    // Single-entry fill with read-during-write on the same address
    run_cmds(1, 4'd9, 4'd9, 8'h33, 0, 4'd0, 4'd0, 8'h00);
    wait_idle();
    rd_addr = 4'd9;
    step();
    run_cmds(1, 4'd9, 4'd9, 8'h7E, 0, 4'd0, 4'd0, 8'h00);
    check("rdw_busy", busy, 1);
    step();
    check("rdw_old", rd_data, 8'h33);
    check("rdw_busy_off", busy, 0);
    check("rdw_done", a_done, 1);
    step();
    check("rdw_new", rd_data, 8'h7E);
    check("rdw_done_off", a_done, 0);

    // Reset mid-fill aborts without a done pulse
    run_cmds(1, 4'd0, 4'd15, 8'hFF, 0, 4'd0, 4'd0, 8'h00);
    repeat (4) step();
    do_reset(2);
    check("midrst_a_done", a_done, 0);
    for (int i = 0; i < 16; i++) read_chk("midrst_sweep", 4'(i), 8'h00);
    a_valid = 1; a_start = 3; a_end = 4; a_data = 8'h44;
    #1;
    check("midrst_accept", a_ready, 1);
    run_cmds(1, 4'd3, 4'd4, 8'h44, 0, 4'd0, 4'd0, 8'h00);
    wait_idle();

    // Randomized traffic, with occasional resets
    for (int c = 0; c < 600; c++) begin
      rst_n   = ($urandom_range(0, 99) != 0);
      a_valid = ($urandom_range(0, 2) == 0);
      b_valid = ($urandom_range(0, 2) == 0);
      a_start = 4'($urandom); a_end = 4'($urandom); a_data = 8'($urandom);
      b_start = 4'($urandom); b_end = 4'($urandom); b_data = 8'($urandom);
      rd_addr = 4'($urandom);
      step();
    end
    rst_n = 1; a_valid = 0; b_valid = 0;
    wait_idle();
    for (int i = 0; i < 16; i++) read_chk("rand_sweep", 4'(i), m_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fill_arbiter.md
# fill_arbiter

- Owns a DEPTH×DW register array and shares its single write port between two requesters, A and B.
- Each requester issues a range-fill command (start, end, data); the block serializes fills one word per cycle, arbitrating round-robin at command granularity.
- A registered read port lets downstream logic sample the array.
- This is the single driver of the array: requesters never write storage directly.

## Interface
- DW, 8, data width of each array entry
- DEPTH, 16, number of entries (power of two)
- AW, 4, address width, log2(DEPTH)
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- a_valid  input  1  requester A command valid
- a_ready  output  1  A command accepted this cycle when a_valid & a_ready
- a_start  input  AW  A first address
- a_end  input  AW  A last address (inclusive)
- a_data  input  DW  A fill value
- a_done  output  1  one-cycle pulse: A fill complete
- b_valid, b_ready, b_start, b_end, b_data, b_done: same as A, for requester B
- rd_addr  input  AW  read address
- rd_data  output  DW  registered read data
- busy  output  1  high while a fill is in progress

## Operation
- States: IDLE, FILL.
- IDLE:
  - At most one ready is asserted, combinationally: a_ready = IDLE & a_valid & (~b_valid | last_grant==B); b_ready is symmetric.
  - If both requesters are valid, the one not granted last wins. last_grant resets to B, so A wins the first tie.
- Accept: latch start, end and data into cur_ptr, cur_end and cur_data; set the owner and last_grant; go to FILL.
- FILL, each cycle:
  - Write mem[cur_ptr] <= cur_data.
  - If cur_ptr == cur_end: go to IDLE and pulse the owner's done next cycle.
  - Otherwise cur_ptr <= cur_ptr+1, modulo DEPTH.
- Fill length L = ((end − start) mod DEPTH) + 1:
  - start > end wraps through DEPTH−1 to 0.
  - start == end writes exactly one entry.
  - A full DEPTH-entry fill uses end = start−1.
- Command inputs are ignored outside the accept cycle. Changing them during FILL has no effect.
- Read: rd_data <= mem[rd_addr] every cycle. A read of the address being written in the same cycle returns the old value.
- busy = (state == FILL).
- Reset (rst_n low at an edge):
  - state=IDLE, last_grant=B.
  - All array entries = 0.
  - rd_data=0, a_done=b_done=0.
  - Any fill in progress is aborted with no done pulse.

## Timing
- Accept at edge ending cycle N.
- Writes land at the edges ending cycles N+1 … N+L; busy is high in cycles N+1 … N+L.
- Owner's done is high in cycle N+L+1 only. State is IDLE in that cycle, so the next accept can occur at the edge ending N+L+1. Minimum command-to-command spacing is L+1 cycles.
- Read latency: 1 cycle.
- Reset values: a_ready=b_ready=0 while no valid; a_done=b_done=busy=0; rd_data=0.
- A requester that stays valid while losing a tie is not dropped. It wins the next IDLE arbitration if the other requester was last granted.

## Test plan
- **Reset:** rst_n low 2 cycles, then sweep rd_addr 0..15 → rd_data=0x00 everywhere; busy=a_done=b_done=0.
- **Single fill:** A alone, start=1, end=6, data=0x5A, accepted at cycle N.
  - busy high for cycles N+1..N+6; a_done high at N+7 only.
  - Entries 1..6=0x5A; entries 0 and 7..15=0x00.
- **Simultaneous requests after reset:** A (0..3, 0x11) and B (2..5, 0x22) both valid.
  - A accepted first; B accepted at the edge ending N+5.
  - Final array: 0..1=0x11, 2..5=0x22. a_done at N+5, b_done at N+10.
- **Wrap-around:** B start=14, end=1, data=0xC3.
  - Exactly entries 14, 15, 0, 1 are written over 4 cycles; entry 2 is unchanged.
- **Single-entry fill and read-during-write:** A start=end=9, data=0x7E, with rd_addr=9 held.
  - rd_data shows the old value the cycle after the write edge, then 0x7E.
  - busy is high for 1 cycle.
- **Reset mid-fill:** A fill 0..15 of 0xFF; assert rst_n low 5 cycles after accept.
  - No a_done pulse; all entries read 0x00.
  - A new A command is accepted on the first valid cycle after reset.
